// File: rtl/ss_pkg.sv
// Shared types and constants for the save-state sequencer.
// Index slot and default geometry of the mapper save-state port.
package ss_pkg;

  localparam int unsigned REG_CNT_DEF  = 16;
  localparam int unsigned IDX_SLOT_DEF = 127;
  localparam int unsigned SETTLE_DEF   = 4;
  localparam int unsigned MEM_BASE_DEF = 0;
  localparam int unsigned SETTLE_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    SV_ADDR,
    SV_MEM,
    LD_CHK,
    LD_MEM,
    LD_WR,
    LD_GAP,
    FIN
  } ss_state_e;

  // Buffer addresses wrap modulo 256.
  function automatic logic [7:0] buf_addr(input logic [7:0] base, input logic [7:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/ss_settle_cnt.sv
// Load/countdown timer holding the mapper port stable for a programmable number of cycles.
// The zero flag is high on the final settle cycle and while idle.
module ss_settle_cnt
  import ss_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  output logic                zero_o
);

  logic [SETTLE_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - SETTLE_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ss_seq.sv
// Save-state sequencer: copies mapper state slots to an external buffer and restores them.
//   state   | meaning
//   IDLE    | waiting for cmd_save / cmd_load
//   SV_ADDR | ss_addr = slot, settling before sampling ss_rdat
//   SV_MEM  | buffer write of the sampled slot byte, waiting for mem_ack
//   LD_CHK  | buffer read of the stored mapper index, compared on ack
//   LD_MEM  | buffer read of the next slot byte
//   LD_WR   | ss_we high for SETTLE cycles
//   LD_GAP  | ss_we low for one cycle before ss_addr moves on
//   FIN     | done pulse, ss_act low
module ss_seq
  import ss_pkg::*;
#(
  parameter int unsigned REG_CNT  = REG_CNT_DEF,
  parameter int unsigned IDX_SLOT = IDX_SLOT_DEF,
  parameter int unsigned SETTLE   = SETTLE_DEF,
  parameter int unsigned MEM_BASE = MEM_BASE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_save,
  input  logic       cmd_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdat,
  input  logic [7:0] mem_rdat,
  input  logic       mem_ack
);

  localparam int unsigned SW = $clog2(REG_CNT + 1);
  localparam logic [SW-1:0] LAST_REG = SW'(REG_CNT - 1);
  // Slot counter value REG_CNT stands for the mapper-index slot.
  localparam logic [SW-1:0] IDX_POS = SW'(REG_CNT);
  localparam logic [7:0] IDX_SLOT_B = 8'(IDX_SLOT);
  localparam logic [7:0] MEM_BASE_B = 8'(MEM_BASE);
  localparam logic [7:0] IDX_OFS_B  = 8'(REG_CNT);
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE - 1);

  ss_state_e   state_q;
  logic [SW-1:0] slot_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        ss_act_q;
  logic        ss_we_q;
  logic [7:0]  ss_addr_q;
  logic [7:0]  ss_wdat_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [7:0]  mem_addr_q;
  logic [7:0]  mem_wdat_q;

  logic          ack_ok;
  logic          settle_load;
  logic          settle_zero;
  logic [SW-1:0] slot_inc;

  function automatic logic [7:0] slot_to_addr(input logic [SW-1:0] s);
    if (s == IDX_POS) return IDX_SLOT_B;
    return 8'(s);
  endfunction

  assign ack_ok   = mem_ack & mem_req_q;
  assign slot_inc = slot_q + SW'(1);

  // The timer is loaded on the same edge that enters SV_ADDR or LD_WR.
  always_comb begin
    settle_load = 1'b0;
    case (state_q)
      IDLE:    settle_load = cmd_save;
      SV_MEM:  settle_load = ack_ok && (slot_q != IDX_POS);
      LD_MEM:  settle_load = ack_ok;
      default: settle_load = 1'b0;
    endcase
  end

  ss_settle_cnt u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (settle_load),
    .load_val_i (SETTLE_LD),
    .zero_o     (settle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ss_act_q   <= 1'b0;
      ss_we_q    <= 1'b0;
      ss_addr_q  <= '0;
      ss_wdat_q  <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wdat_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (cmd_save) begin
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            ss_act_q  <= 1'b1;
            slot_q    <= '0;
            ss_addr_q <= slot_to_addr('0);
            state_q   <= SV_ADDR;
          end else if (cmd_load) begin
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            ss_act_q   <= 1'b1;
            slot_q     <= '0;
            ss_addr_q  <= IDX_SLOT_B;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= buf_addr(MEM_BASE_B, IDX_OFS_B);
            state_q    <= LD_CHK;
          end
        end

        SV_ADDR: begin
          if (settle_zero) begin
            mem_wdat_q <= ss_rdat;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= buf_addr(MEM_BASE_B, 8'(slot_q));
            state_q    <= SV_MEM;
          end
        end

        SV_MEM: begin
          if (ack_ok) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (slot_q == IDX_POS) begin
              busy_q    <= 1'b0;
              ss_act_q  <= 1'b0;
              done_q    <= 1'b1;
              ss_addr_q <= '0;
              state_q   <= FIN;
            end else begin
              slot_q    <= slot_inc;
              ss_addr_q <= slot_to_addr(slot_inc);
              state_q   <= SV_ADDR;
            end
          end
        end

        LD_CHK: begin
          if (ack_ok) begin
            if (mem_rdat != ss_rdat) begin
              mem_req_q <= 1'b0;
              err_q     <= 1'b1;
              busy_q    <= 1'b0;
              ss_act_q  <= 1'b0;
              done_q    <= 1'b1;
              ss_addr_q <= '0;
              state_q   <= FIN;
            end else begin
              // Back-to-back request: the index read completes on this edge.
              mem_req_q  <= 1'b1;
              mem_addr_q <= buf_addr(MEM_BASE_B, 8'h00);
              slot_q     <= '0;
              state_q    <= LD_MEM;
            end
          end
        end

        LD_MEM: begin
          if (ack_ok) begin
            mem_req_q <= 1'b0;
            ss_wdat_q <= mem_rdat;
            ss_addr_q <= slot_to_addr(slot_q);
            ss_we_q   <= 1'b1;
            state_q   <= LD_WR;
          end
        end

        LD_WR: begin
          if (settle_zero) begin
            ss_we_q <= 1'b0;
            state_q <= LD_GAP;
          end
        end

        LD_GAP: begin
          if (slot_q == LAST_REG) begin
            busy_q    <= 1'b0;
            ss_act_q  <= 1'b0;
            done_q    <= 1'b1;
            ss_addr_q <= '0;
            state_q   <= FIN;
          end else begin
            slot_q     <= slot_inc;
            mem_req_q  <= 1'b1;
            mem_addr_q <= buf_addr(MEM_BASE_B, 8'(slot_inc));
            state_q    <= LD_MEM;
          end
        end

        FIN: begin
          done_q  <= 1'b0;
          slot_q  <= '0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ss_act   = ss_act_q;
  assign ss_we    = ss_we_q;
  assign ss_addr  = ss_addr_q;
  assign ss_wdat  = ss_wdat_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdat = mem_wdat_q;

endmodule

// File: tb/tb_ss_seq.sv
// Bench for ss_seq: mapper and buffer models, write recorder, directed and randomized sequences.
module tb_ss_seq;

  localparam int REG_CNT  = 16;
  localparam int IDX_SLOT = 127;
  localparam int SETTLE   = 4;
  localparam int MEM_BASE = 0;
  localparam int SAVE_CYC = 1 + (REG_CNT + 1) * (SETTLE + 2) + 1;
  localparam int LOAD_CYC = 1 + 2 + REG_CNT * (2 + SETTLE + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_save, cmd_load;
  logic       busy, done, err;
  logic       ss_act, ss_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdat;
  logic [7:0] mem_rdat;
  logic       mem_ack;

  int n_chk = 0;
  int n_err = 0;

  ss_seq #(
    .REG_CNT (REG_CNT),
    .IDX_SLOT(IDX_SLOT),
    .SETTLE  (SETTLE),
    .MEM_BASE(MEM_BASE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_save(cmd_save),
    .cmd_load(cmd_load),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .ss_act  (ss_act),
    .ss_we   (ss_we),
    .ss_addr (ss_addr),
    .ss_wdat (ss_wdat),
    .ss_rdat (ss_rdat),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat),
    .mem_ack (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mapper model: live registers plus a read-only index byte.
  logic [7:0] map_reg [REG_CNT];
  logic [7:0] map_idx;
  always_comb begin
    ss_rdat = 8'h00;
    if (ss_addr < 8'(REG_CNT)) ss_rdat = map_reg[ss_addr[3:0]];
    else if (ss_addr == 8'(IDX_SLOT)) ss_rdat = map_idx;
  end

  // Buffer model with configurable ack delay.
  logic [7:0] buffer [256];
  bit         rand_ack = 1'b0;
  bit         pend = 1'b0;
  int         wait_cnt = 0;
  logic [7:0] cap_addr, cap_wdat;
  logic       cap_we;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      pend    = 1'b0;
    end else begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        pend    = 1'b0;
      end
      if (pend) begin
        check("mem_req_held", 32'(mem_req), 32'd1);
        check("mem_addr_stable", 32'(mem_addr), 32'(cap_addr));
        check("mem_we_stable", 32'(mem_we), 32'(cap_we));
        if (cap_we) check("mem_wdat_stable", 32'(mem_wdat), 32'(cap_wdat));
      end else if (mem_req) begin
        pend     = 1'b1;
        wait_cnt = rand_ack ? int'($urandom_range(0, 7)) : 1;
        cap_addr = mem_addr;
        cap_we   = mem_we;
        cap_wdat = mem_wdat;
      end
      if (pend) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          if (cap_we) buffer[cap_addr] = cap_wdat;
          else mem_rdat = buffer[cap_addr];
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Mapper write recorder.
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         width;
  } wr_t;
  wr_t  wr_q[$];
  wr_t  cur;
  logic we_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      we_prev = 1'b0;
    end else begin
      if (ss_we) begin
        if (!we_prev) begin
          cur.addr  = ss_addr;
          cur.data  = ss_wdat;
          cur.width = 1;
        end else begin
          cur.width++;
          check("ss_addr_stable_we", 32'(ss_addr), 32'(cur.addr));
          check("ss_wdat_stable_we", 32'(ss_wdat), 32'(cur.data));
        end
      end else if (we_prev) begin
        wr_q.push_back(cur);
      end
      we_prev = ss_we;
    end
  end

  int done_cnt = 0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("busy_low_at_done", 32'(busy), 32'd0);
      check("ss_act_low_at_done", 32'(ss_act), 32'd0);
    end
  end

  task automatic run_cmd(input logic sv, input logic ld, output int cyc);
    cmd_save = sv;
    cmd_load = ld;
    cyc = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cmd_save = 1'b0;
      cmd_load = 1'b0;
      cyc++;
      if (done) return;
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_save(input string tag);
    for (int n = 0; n < REG_CNT; n++)
      check(tag, 32'(buffer[MEM_BASE + n]), 32'(map_reg[n]));
    check({tag, "_idx"}, 32'(buffer[MEM_BASE + REG_CNT]), 32'(map_idx));
  endtask

  task automatic check_load(input string tag);
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(REG_CNT));
    for (int n = 0; n < REG_CNT; n++) begin
      if (n < wr_q.size()) begin
        check({tag, "_addr"}, 32'(wr_q[n].addr), 32'(n));
        check({tag, "_data"}, 32'(wr_q[n].data), 32'(buffer[MEM_BASE + n]));
        check({tag, "_width"}, 32'(wr_q[n].width), 32'(SETTLE));
      end
    end
  endtask

  initial begin
    int cyc;
    int d0;
    bit found;

    rst_n = 1'b0;
    cmd_save = 1'b0;
    cmd_load = 1'b0;
    mem_rdat = 8'h00;
    mem_ack  = 1'b0;
    map_idx  = 8'h40;
    for (int n = 0; n < REG_CNT; n++) map_reg[n] = 8'(8'h10 + n);
    for (int a = 0; a < 256; a++) buffer[a] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ss_act", 32'(ss_act), 32'd0);
    check("rst_ss_we", 32'(ss_we), 32'd0);
    check("rst_ss_addr", 32'(ss_addr), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Save with fixed mapper contents.
    d0 = done_cnt;
    run_cmd(1'b1, 1'b0, cyc);
    check("save_cycles", 32'(cyc), 32'(SAVE_CYC));
    check_save("save_buf");
    check("save_no_ss_we", 32'(wr_q.size()), 32'd0);
    @(negedge clk);
    check("save_done_once", 32'(done_cnt - d0), 32'd1);
    check("save_err", 32'(err), 32'd0);

    // Load with matching index.
    for (int n = 0; n < REG_CNT; n++) buffer[MEM_BASE + n] = 8'(8'hA0 + n);
    buffer[MEM_BASE + REG_CNT] = 8'h40;
    wr_q.delete();
    run_cmd(1'b0, 1'b1, cyc);
    check("load_cycles", 32'(cyc), 32'(LOAD_CYC));
    @(negedge clk);
    check_load("load");
    check("load_err", 32'(err), 32'd0);

    // Load with mismatching index.
    buffer[MEM_BASE + REG_CNT] = 8'h05;
    wr_q.delete();
    d0 = done_cnt;
    run_cmd(1'b0, 1'b1, cyc);
    check("mism_err", 32'(err), 32'd1);
    check("mism_cycles", 32'(cyc), 32'd4);
    repeat (2) @(negedge clk);
    check("mism_no_we", 32'(wr_q.size()), 32'd0);
    check("mism_done", 32'(done_cnt - d0), 32'd1);
    check("mism_ss_act", 32'(ss_act), 32'd0);
    check("mism_err_sticky", 32'(err), 32'd1);
    run_cmd(1'b1, 1'b0, cyc);
    check("err_cleared_by_save", 32'(err), 32'd0);
    @(negedge clk);

    // Simultaneous commands: save wins.
    for (int n = 0; n < REG_CNT; n++) map_reg[n] = 8'($urandom_range(0, 255));
    map_idx = 8'($urandom_range(0, 255));
    wr_q.delete();
    run_cmd(1'b1, 1'b1, cyc);
    check("both_cycles", 32'(cyc), 32'(SAVE_CYC));
    check_save("both_buf");
    @(negedge clk);
    check("both_no_we", 32'(wr_q.size()), 32'd0);

    // Load pulsed mid-save is dropped.
    d0 = done_cnt;
    cmd_save = 1'b1;
    @(negedge clk);
    cmd_save = 1'b0;
    repeat (30) @(negedge clk);
    cmd_load = 1'b1;
    @(negedge clk);
    cmd_load = 1'b0;
    repeat (200) @(negedge clk);
    check("midsave_done_once", 32'(done_cnt - d0), 32'd1);
    check("midsave_idle", 32'(busy), 32'd0);
    check("midsave_no_we", 32'(wr_q.size()), 32'd0);

    // Random ack delay on save, then on a random-content load.
    rand_ack = 1'b1;
    for (int n = 0; n < REG_CNT; n++) map_reg[n] = 8'(8'h10 + n);
    map_idx = 8'h40;
    d0 = done_cnt;
    run_cmd(1'b1, 1'b0, cyc);
    check_save("rsave_buf");
    @(negedge clk);
    check("rsave_done", 32'(done_cnt - d0), 32'd1);
    for (int n = 0; n < REG_CNT; n++) buffer[MEM_BASE + n] = 8'($urandom_range(0, 255));
    wr_q.delete();
    run_cmd(1'b0, 1'b1, cyc);
    @(negedge clk);
    check_load("rload");
    check("rload_err", 32'(err), 32'd0);
    rand_ack = 1'b0;

    // Reset while slot 7 is being written, then a clean load.
    for (int n = 0; n < REG_CNT; n++) buffer[MEM_BASE + n] = 8'(8'hA0 + n);
    d0 = done_cnt;
    cmd_load = 1'b1;
    @(negedge clk);
    cmd_load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ss_we && ss_addr == 8'd7) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_ldwr7_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_ss_we", 32'(ss_we), 32'd0);
    check("arst_ss_act", 32'(ss_act), 32'd0);
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("arst_no_done", 32'(done_cnt - d0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_q.delete();
    run_cmd(1'b0, 1'b1, cyc);
    check("post_rst_cycles", 32'(cyc), 32'(LOAD_CYC));
    @(negedge clk);
    check_load("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ss_seq.md
Name: ss_seq

Overview:
- Save-state sequencer for a mapper's save-state port (ss_act/ss_we/ss_addr/ss_rdat).
- On save, walks register slots 0..REG_CNT-1 plus the mapper-index slot and copies each byte into an external state buffer.
- On load, checks the stored mapper index against the live one, then writes the stored bytes back into the mapper.
- Sits between the system menu/firmware command path and the active mapper module.

Parameters:
- REG_CNT, 16, number of contiguous mapper state slots (ss_addr 0..REG_CNT-1).
- IDX_SLOT, 127, ss_addr of the read-only mapper-index byte.
- SETTLE, 4, clk cycles ss_addr/ss_we are held stable per slot (covers mapper m2-domain capture); legal range 1..15.
- MEM_BASE, 0, buffer address of slot 0; the index byte is stored at MEM_BASE+REG_CNT.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- cmd_save, input, 1, single-cycle start-save pulse.
- cmd_load, input, 1, single-cycle start-load pulse.
- busy, output, 1, high while a sequence is in progress.
- done, output, 1, one-cycle pulse at sequence end.
- err, output, 1, sticky mapper-index mismatch flag; cleared by the next accepted command.
- ss_act, output, 1, mapper save-state mode enable.
- ss_we, output, 1, mapper state write strobe.
- ss_addr, output, 8, mapper state slot select.
- ss_wdat, output, 8, data written to mapper.
- ss_rdat, input, 8, mapper state readback.
- mem_req, output, 1, buffer access request; held until mem_ack.
- mem_we, output, 1, 1 = buffer write, 0 = buffer read.
- mem_addr, output, 8, buffer address.
- mem_wdat, output, 8, buffer write data.
- mem_rdat, input, 8, buffer read data; valid in the mem_ack cycle.
- mem_ack, input, 1, one-cycle completion of a buffer access.

Behaviour:
- Reset, asynchronous: state IDLE, all outputs 0, internal counters 0.
- IDLE:
  - cmd_save wins over cmd_load when both are high.
  - Commands arriving while busy are ignored; none are queued.
  - An accepted command clears err and sets busy and ss_act on the next cycle.
- Save sequence, slot list 0..REG_CNT-1 then IDX_SLOT:
  - SV_ADDR: drive ss_addr = slot and count SETTLE cycles.
  - SV_MEM: latch ss_rdat into mem_wdat; mem_req=1, mem_we=1, mem_addr = MEM_BASE+index.
  - On mem_ack, drop mem_req and advance; after the IDX_SLOT write go to FIN.
- Load sequence:
  - LD_CHK: read buffer MEM_BASE+REG_CNT while ss_addr=IDX_SLOT.
  - On mem_ack, compare mem_rdat with ss_rdat. Mismatch: set err and go to FIN; no mapper write occurs.
  - Per slot, LD_MEM: read buffer MEM_BASE+slot and capture mem_rdat into ss_wdat on ack.
  - Per slot, LD_WR: ss_addr = slot, ss_we=1 for SETTLE cycles, then ss_we=0 for one gap cycle before the address changes.
  - IDX_SLOT is never written to the mapper.
- FIN:
  - ss_act deasserts.
  - done pulses one cycle; busy drops in the same cycle.
  - Return to IDLE.
- ss_addr and ss_wdat never change while ss_we=1.
- mem_addr, mem_we and mem_wdat are stable while mem_req=1.
- Counters:
  - slot counter width is clog2(REG_CNT+1); settle counter is 4 bits.
  - mem_addr is computed mod 256.
- Latency with mem_ack one cycle after mem_req:
  - save = 1 + (REG_CNT+1)*(SETTLE+2) + 1 cycles.
  - load with index match = 1 + 2 + REG_CNT*(2+SETTLE+1) + 1 cycles.
- mem_ack outside a mem_req cycle is ignored.
- Reset mid-sequence aborts immediately: ss_act, ss_we and mem_req go to 0 asynchronously; no done pulse.

Decomposition:
- Shared package ss_pkg:
  - state encoding enum (IDLE, SV_ADDR, SV_MEM, LD_CHK, LD_MEM, LD_WR, LD_GAP, FIN).
  - slot/index constants IDX_SLOT=127 and the default REG_CNT.
- One natural sub-module, ss_settle_cnt: a load/countdown timer with a zero flag, reused by SV_ADDR and LD_WR.

Test Plan:
- Save, with the mapper model holding slot n = 0x10+n and index 0x40, mem_ack at 1 cycle: buffer[0..15] = 0x10..0x1F, buffer[16] = 0x40, done once, cycle count 1+17*6+1 = 104.
- Load with buffer[16]=0x40 matching and buffer[n] = 0xA0+n: the mapper receives 16 writes of 0xA0..0xAF at ss_addr 0..15, each with ss_we high exactly 4 cycles; no write to slot 127; err=0.
- Load with buffer[16]=0x05 mismatching: err=1, zero ss_we pulses, done pulses, ss_act low afterwards; a following cmd_save clears err.
- cmd_save and cmd_load in the same cycle → save runs; a cmd_load pulsed mid-save → ignored, exactly one done.
- Random mem_ack delay of 0–7 cycles on a save: mem_addr, mem_wdat and mem_we are stable while mem_req=1, and the final buffer matches the first scenario.
- rst_n low during LD_WR slot 7 → ss_we, ss_act and mem_req are 0 in the same cycle, busy=0, no done; a subsequent load completes normally.
